// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: generic chain of STAGES register slices carrying a DATA_W
// payload with a ready/valid handshake, bubble collapse, synchronous flush
// and an occupancy count.
//
// Build option: define PIPE_STAGE_CHAIN_SKID_EN to place a one-entry skid
// register ahead of slice 0. in_ready then comes from a register instead of
// the combinational out_ready path, and capacity grows to STAGES+1.
module pipe_stage_chain #(
    parameter int                DATA_W      = 32,
    parameter int                STAGES      = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic [$clog2(STAGES+2)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(STAGES + 2);

    // Slice state; index 0 is the input side, STAGES-1 drives the outputs.
    logic [STAGES-1:0] valid_reg;
    logic [DATA_W-1:0] data_reg [STAGES];
    logic [STAGES-1:0] valid_next;
    logic [DATA_W-1:0] data_next [STAGES];

    // ready[k]: slice k may load this cycle (it is empty or its content moves on).
    logic [STAGES-1:0] ready;

    // What each slice would load: the previous slice, or the head for slice 0.
    logic [STAGES-1:0] src_valid;
    logic [DATA_W-1:0] src_data [STAGES];

    // Entry offered to slice 0 (new input, or the skid entry when present).
    logic              head_valid;
    logic [DATA_W-1:0] head_data;

    logic              in_fire;
    logic              out_fire;
    logic [OCC_W-1:0]  occ_reg;
    logic [OCC_W-1:0]  occ_next;

`ifdef PIPE_STAGE_CHAIN_SKID_EN
    logic              skid_valid_reg;
    logic [DATA_W-1:0] skid_data_reg;
`endif

    // Per-slice ready and source wiring. ready[k] is written as "not every
    // slice from k to the output is full, or the output drains" which is the
    // unrolled form of ready[k] = !valid[k] || ready[k+1]; it avoids a
    // self-referencing vector while producing the same combinational chain.
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_slice
        assign ready[gi] = out_ready || !(&valid_reg[STAGES-1:gi]);
        if (gi == 0) begin : g_head
            assign src_valid[gi] = head_valid;
            assign src_data[gi]  = head_data;
        end else begin : g_link
            assign src_valid[gi] = valid_reg[gi-1];
            assign src_data[gi]  = data_reg[gi-1];
        end
    end

`ifdef PIPE_STAGE_CHAIN_SKID_EN
    // in_ready depends only on the skid register, so the out_ready -> in_ready
    // path is cut; the skid entry has priority over new input into slice 0.
    assign in_ready   = reset_n && !flush && !skid_valid_reg;
    assign in_fire    = in_valid && in_ready;
    assign head_valid = skid_valid_reg || in_fire;
    assign head_data  = skid_valid_reg ? skid_data_reg : in_data;

    // Skid register: catch an accepted input slice 0 cannot take, drain it
    // as soon as slice 0 becomes ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= CLEAR_VALUE;
        end else if (flush) begin
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= CLEAR_VALUE;
        end else if (skid_valid_reg) begin
            if (ready[0]) begin
                skid_valid_reg <= 1'b0;
            end
        end else if (in_fire && !ready[0]) begin
            skid_valid_reg <= 1'b1;
            skid_data_reg  <= in_data;
        end
    end
`else
    // Without a skid stage the input is accepted exactly when slice 0 can load.
    assign in_ready   = reset_n && !flush && ready[0];
    assign in_fire    = in_valid && in_ready;
    assign head_valid = in_fire;
    assign head_data  = in_data;
`endif

    // Consumer ignores out_valid during flush, so no output transfer is counted.
    assign out_valid = valid_reg[STAGES-1];
    assign out_data  = data_reg[STAGES-1];
    assign out_fire  = out_valid && out_ready && !flush;

    // Next slice contents: a ready slice takes its source; data only loads
    // when the incoming entry is valid so out_data keeps the last real value.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            valid_next[k] = valid_reg[k];
            data_next[k]  = data_reg[k];
            if (ready[k]) begin
                valid_next[k] = src_valid[k];
                if (src_valid[k]) begin
                    data_next[k] = src_data[k];
                end
            end
        end
    end

    // Slice registers; flush squashes every in-flight entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_reg <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_reg[k] <= CLEAR_VALUE;
            end
        end else if (flush) begin
            valid_reg <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_reg[k] <= CLEAR_VALUE;
            end
        end else begin
            valid_reg <= valid_next;
            for (int k = 0; k < STAGES; k++) begin
                data_reg[k] <= data_next[k];
            end
        end
    end

    // Occupancy follows the handshakes: +1 per input, -1 per output transfer.
    assign occ_next = occ_reg + OCC_W'(in_fire) - OCC_W'(out_fire);

    // Occupancy register, cleared by flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_reg <= '0;
        end else if (flush) begin
            occ_reg <= '0;
        end else begin
            occ_reg <= occ_next;
        end
    end

    assign occupancy = occ_reg;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: three instances (STAGES=3, 2 and 4)
// exercised one after another from a single linear stimulus sequence.
// Expectations that depend on PIPE_STAGE_CHAIN_SKID_EN use the same macro.
module tb_pipe_stage_chain;

`ifdef PIPE_STAGE_CHAIN_SKID_EN
    localparam int SKID = 1;
`else
    localparam int SKID = 0;
`endif
    localparam int CAP3 = 3 + SKID;
    localparam int CAP4 = 4 + SKID;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    // Instance a: STAGES=3, CLEAR_VALUE=0
    logic       a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [7:0] a_in_data = 8'h00;
    logic       a_in_ready, a_out_valid;
    logic [7:0] a_out_data;
    logic [2:0] a_occ;

    // Instance b: STAGES=2, CLEAR_VALUE=E7
    logic       b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [7:0] b_in_data = 8'h00;
    logic       b_in_ready, b_out_valid;
    logic [7:0] b_out_data;
    logic [1:0] b_occ;

    // Instance c: STAGES=4, 16-bit payload, randomized handshake
    logic        c_flush = 1'b0, c_in_valid = 1'b0, c_out_ready = 1'b0;
    logic [15:0] c_in_data = 16'h0000;
    logic        c_in_ready, c_out_valid;
    logic [15:0] c_out_data;
    logic [2:0]  c_occ;

    pipe_stage_chain #(.DATA_W(8), .STAGES(3), .CLEAR_VALUE(8'h00)) u_a (
        .clk(clk), .reset_n(reset_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    pipe_stage_chain #(.DATA_W(8), .STAGES(2), .CLEAR_VALUE(8'hE7)) u_b (
        .clk(clk), .reset_n(reset_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    pipe_stage_chain #(.DATA_W(16), .STAGES(4), .CLEAR_VALUE(16'h0000)) u_c (
        .clk(clk), .reset_n(reset_n), .flush(c_flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .occupancy(c_occ)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  drain_exp [4];
    logic [15:0] q [$];
    logic [15:0] next_val;

    initial begin
        drain_exp[0] = 8'hA1;
        drain_exp[1] = 8'hA2;
        drain_exp[2] = 8'hA3;
        drain_exp[3] = 8'hA4;
        next_val     = 16'h1000;

        // ---------------- reset ----------------
        #1 reset_n = 1'b0;
        #1;
        check("rst_a_in_ready", 32'(a_in_ready), 0);
        check("rst_a_out_valid", 32'(a_out_valid), 0);
        check("rst_a_occ", 32'(a_occ), 0);
        check("rst_a_out_data", 32'(a_out_data), 'h00);
        check("rst_b_out_data", 32'(b_out_data), 'hE7);
        check("rst_b_out_valid", 32'(b_out_valid), 0);
        @(posedge clk);
        #1;
        check("rst_hold_in_ready", 32'(a_in_ready), 0);
        #6 reset_n = 1'b1;
        #1;
        check("rst_rel_in_ready", 32'(a_in_ready), 1);
        tick();

        // ---------------- streaming, out_ready=1 ----------------
        $display("phase stream: push 11 22 33 with out_ready=1");
        a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 8'h11;
        #1;
        check("t1_in_ready", 32'(a_in_ready), 1);
        check("t1_occ0", 32'(a_occ), 0);
        tick(); a_in_data = 8'h22; #1;
        check("t1_occ1", 32'(a_occ), 1);
        check("t1_ov_e1", 32'(a_out_valid), 0);
        tick(); a_in_data = 8'h33; #1;
        check("t1_occ2", 32'(a_occ), 2);
        check("t1_ov_e2", 32'(a_out_valid), 0);
        tick(); a_in_valid = 1'b0; #1;
        check("t1_ov_11", 32'(a_out_valid), 1);
        check("t1_od_11", 32'(a_out_data), 'h11);
        check("t1_occ_peak", 32'(a_occ), 3);
        tick(); #1;
        check("t1_ov_22", 32'(a_out_valid), 1);
        check("t1_od_22", 32'(a_out_data), 'h22);
        check("t1_occ_d2", 32'(a_occ), 2);
        tick(); #1;
        check("t1_ov_33", 32'(a_out_valid), 1);
        check("t1_od_33", 32'(a_out_data), 'h33);
        check("t1_occ_d1", 32'(a_occ), 1);
        tick(); #1;
        check("t1_ov_empty", 32'(a_out_valid), 0);
        check("t1_occ_empty", 32'(a_occ), 0);

        // ---------------- bubble collapse under stall ----------------
        $display("phase collapse: one entry 44 with out_ready=0");
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h44;
        #1;
        check("t3_in_ready", 32'(a_in_ready), 1);
        tick(); a_in_valid = 1'b0; #1;
        check("t3_ov_s0", 32'(a_out_valid), 0);
        check("t3_occ", 32'(a_occ), 1);
        tick(); #1;
        check("t3_ov_s1", 32'(a_out_valid), 0);
        tick(); #1;
        check("t3_ov_s2", 32'(a_out_valid), 1);
        check("t3_od_s2", 32'(a_out_data), 'h44);
        tick(); #1;
        check("t3_ov_hold", 32'(a_out_valid), 1);
        check("t3_od_hold", 32'(a_out_data), 'h44);
        check("t3_occ_hold", 32'(a_occ), 1);
        a_out_ready = 1'b1;
        tick(); a_out_ready = 1'b0; #1;
        check("t3_ov_drained", 32'(a_out_valid), 0);
        check("t3_occ_drained", 32'(a_occ), 0);

        // ---------------- full stall, then drain ----------------
        $display("phase full: push A1..A5 with out_ready=0, then drain");
        a_in_valid = 1'b1; a_in_data = 8'hA1; #1;
        check("t2_rdy_a1", 32'(a_in_ready), 1);
        tick(); a_in_data = 8'hA2; #1;
        check("t2_rdy_a2", 32'(a_in_ready), 1);
        check("t2_occ1", 32'(a_occ), 1);
        tick(); a_in_data = 8'hA3; #1;
        check("t2_rdy_a3", 32'(a_in_ready), 1);
        check("t2_occ2", 32'(a_occ), 2);
        tick(); a_in_data = 8'hA4; #1;
        check("t2_rdy_a4", 32'(a_in_ready), SKID);
        check("t2_occ3", 32'(a_occ), 3);
        check("t2_ov", 32'(a_out_valid), 1);
        check("t2_od", 32'(a_out_data), 'hA1);
        tick(); a_in_data = (SKID != 0) ? 8'hA5 : 8'hA4; #1;
        check("t2_rdy_full", 32'(a_in_ready), 0);
        check("t2_occ_full", 32'(a_occ), CAP3);
        tick(); #1;
        check("t2_rdy_full2", 32'(a_in_ready), 0);
        check("t2_occ_full2", 32'(a_occ), CAP3);
        check("t2_od_full2", 32'(a_out_data), 'hA1);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        for (int i = 0; i < CAP3; i++) begin
            check("t2_drain_ov", 32'(a_out_valid), 1);
            check("t2_drain_od", 32'(a_out_data), 32'(drain_exp[i]));
            tick(); #1;
        end
        check("t2_drain_end_ov", 32'(a_out_valid), 0);
        check("t2_drain_end_occ", 32'(a_occ), 0);
        a_out_ready = 1'b0;

        // ---------------- flush (STAGES=2) ----------------
        $display("phase flush: two entries in flight, flush with AA offered");
        b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_data = 8'hB1; #1;
        check("t4_rdy_b1", 32'(b_in_ready), 1);
        tick(); b_in_data = 8'hB2; #1;
        tick(); b_flush = 1'b1; b_in_data = 8'hAA; #1;
        check("t4_rdy_flush", 32'(b_in_ready), 0);
        check("t4_occ_pre", 32'(b_occ), 2);
        check("t4_ov_pre", 32'(b_out_valid), 1);
        tick(); b_flush = 1'b0; b_in_valid = 1'b0; #1;
        check("t4_ov_post", 32'(b_out_valid), 0);
        check("t4_occ_post", 32'(b_occ), 0);
        check("t4_od_clear", 32'(b_out_data), 'hE7);
        check("t4_rdy_post", 32'(b_in_ready), 1);
        tick(); #1;
        check("t4_ov_late1", 32'(b_out_valid), 0);
        tick(); #1;
        check("t4_ov_late2", 32'(b_out_valid), 0);
        check("t4_od_late2", 32'(b_out_data), 'hE7);
        b_out_ready = 1'b0;

        // ---------------- asynchronous reset mid-stream ----------------
        $display("phase reset: async reset with entries in flight, then push 55");
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h61;
        tick(); a_in_data = 8'h62;
        tick(); a_in_valid = 1'b0;
        tick(); #1;
        check("t5_ov_pre", 32'(a_out_valid), 1);
        check("t5_od_pre", 32'(a_out_data), 'h61);
        check("t5_occ_pre", 32'(a_occ), 2);
        #2 reset_n = 1'b0;
        #1;
        check("t5_ov_rst", 32'(a_out_valid), 0);
        check("t5_occ_rst", 32'(a_occ), 0);
        check("t5_od_rst", 32'(a_out_data), 'h00);
        check("t5_rdy_rst", 32'(a_in_ready), 0);
        #2 reset_n = 1'b1;
        tick();
        a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 8'h55; #1;
        check("t5_rdy_55", 32'(a_in_ready), 1);
        tick(); a_in_valid = 1'b0; #1;
        check("t5_ov_e0", 32'(a_out_valid), 0);
        tick(); #1;
        check("t5_ov_e1", 32'(a_out_valid), 0);
        tick(); #1;
        check("t5_ov_55", 32'(a_out_valid), 1);
        check("t5_od_55", 32'(a_out_data), 'h55);
        tick(); #1;
        check("t5_ov_done", 32'(a_out_valid), 0);
        check("t5_occ_done", 32'(a_occ), 0);
        a_out_ready = 1'b0;

        // ---------------- random handshake (STAGES=4) ----------------
        $display("phase random: 1000 cycles of 50%% in_valid / out_ready");
        for (int cyc = 0; cyc < 1000; cyc++) begin
            c_in_valid  = 1'($urandom_range(0, 1));
            c_out_ready = 1'($urandom_range(0, 1));
            c_in_data   = next_val;
            #1;
            check("rnd_occ", 32'(c_occ), q.size());
            check("rnd_in_ready", 32'(c_in_ready),
                  32'((q.size() < CAP4) || (SKID == 0 && c_out_ready)));
            check("rnd_ov_without_entry", 32'(c_out_valid && q.size() == 0), 0);
            if (c_out_valid && c_out_ready && q.size() > 0) begin
                check("rnd_out_data", 32'(c_out_data), 32'(q[0]));
                void'(q.pop_front());
            end
            if (c_in_valid && c_in_ready) begin
                q.push_back(next_val);
                next_val = next_val + 16'd1;
            end
            tick();
        end
        c_in_valid  = 1'b0;
        c_out_ready = 1'b1;
        for (int i = 0; i < 16 && q.size() > 0; i++) begin
            #1;
            if (c_out_valid) begin
                check("rnd_drain_data", 32'(c_out_data), 32'(q[0]));
                void'(q.pop_front());
            end
            tick();
        end
        #1;
        check("rnd_drain_left", q.size(), 0);
        check("rnd_drain_occ", 32'(c_occ), 0);
        check("rnd_drain_ov", 32'(c_out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised successor to the fixed per-stage pipeline bus registers (Fetch/Decode/Execute/Memory/Writeback).
- A generic chain of STAGES register slices carrying a flat DATA_W payload, with per-slice valid bits, a ready/valid handshake, bubble collapse, synchronous flush and an occupancy count.
- Sits between any two core stages, or inside a multi-cycle unit.
- Stage buses are packed by the caller into `in_data`.

Parameters:
- DATA_W, 32, payload width in bits (>=1).
- STAGES, 1, number of register slices (1..8); the latency in cycles with no backpressure.
- CLEAR_VALUE, 0, value loaded into every slice's data register on reset and on flush (DATA_W bits).

Ports:
- clk  in  1  clock; rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all in-flight entries.
- in_valid  in  1  upstream presents `in_data`.
- in_ready  out  1  chain accepts `in_data` this cycle.
- in_data  in  DATA_W  payload.
- out_valid  out  1  last slice holds a valid entry.
- out_ready  in  1  downstream accepts; 0 = stall.
- out_data  out  DATA_W  payload of the last slice.
- occupancy  out  $clog2(STAGES+2)  number of valid entries held, including the skid entry when enabled.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - all valid bits = 0, data = CLEAR_VALUE, occupancy = 0.
  - out_valid = 0, out_data = CLEAR_VALUE.
  - in_ready = 1 once reset is released (0 while asserted).
- Transfer rule: an input transfer occurs on a clock edge where in_valid && in_ready. An output transfer occurs where out_valid && out_ready.
- Slice k (0 = input side, STAGES-1 = output) loads from slice k-1 (or the input) when slice k is empty or slice k advances this cycle.
  - Slice advance: ready[k] = !valid[k] || ready[k+1].
  - Output slice: ready[STAGES-1] = !valid[STAGES-1] || out_ready.
  - The ready chain is combinational.
- Bubble collapse: a valid entry moves forward into an empty slice even while out_ready=0. The chain can hold STAGES entries under a full stall.
- Data registers do not load when their valid bit would be 0 (they hold their value). out_data is don't-care when out_valid=0 but must equal the last loaded value.
- Latency: an entry accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. it is visible in the cycle following that edge. Minimum latency is STAGES cycles from acceptance to the downstream handshake.
- Throughput: 1 entry/cycle sustained when out_ready=1.
- Ordering: strict FIFO order; no entry is ever duplicated or dropped except by flush.
- Flush (priority over everything):
  - in_ready = 0 during the flush cycle; the output transfer is suppressed because the consumer must ignore out_valid while flush=1.
  - At the next edge: all valid bits = 0, data = CLEAR_VALUE, occupancy = 0.
  - An in_valid present in the flush cycle is dropped.
- Occupancy:
  - +1 on an input transfer, -1 on an output transfer; unchanged when both happen.
  - Forced to 0 on flush.
  - Never exceeds STAGES (STAGES+1 with skid).
- Full: occupancy==capacity and out_ready=0 -> in_ready=0.
- Empty: out_valid=0; in_ready=1 (absent flush).
- Reset mid-transfer: all in-flight entries are discarded immediately; there is no partial state.

Optional Feature:
- Macro: PIPE_STAGE_CHAIN_SKID_EN.
- Defined:
  - A one-entry skid register sits ahead of slice 0, and in_ready becomes a registered signal: in_ready = !skid_valid.
  - This breaks the combinational out_ready->in_ready path.
  - An input arriving while slice 0 cannot load is captured in the skid register; the skid drains into slice 0 with priority over new input.
  - Capacity is STAGES+1; latency is unchanged when unstalled.
  - Flush also clears the skid.
- Undefined: no skid register; in_ready = ready[0] (combinational); capacity is STAGES.

Test Plan:
- STAGES=3, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on consecutive cycles, first one 3 cycles after acceptance; occupancy peaks at 3.
- STAGES=3, out_ready=0, push 5 entries -> 3 accepted, in_ready=0 after the third, occupancy=3 (4 with skid). Release out_ready -> entries drain in order, no loss.
- STAGES=3, push one entry then hold in_valid=0 with out_ready=0 -> entry collapses to the output slice within 3 cycles; out_valid=1, out_data held stable.
- STAGES=2, two entries in flight, assert flush with in_valid=1, data 0xAA -> next cycle out_valid=0, occupancy=0, 0xAA never appears, out_data=CLEAR_VALUE.
- Assert reset_n=0 mid-stream, asynchronously between edges -> out_valid=0 and occupancy=0 immediately. After release, the first push of 0x55 emerges after STAGES cycles.
- Random in_valid/out_ready (50%) for 1000 cycles, STAGES=4, with and without skid -> output sequence equals input sequence; occupancy matches a scoreboard every cycle.
